// File: rtl/adder16_accum_seq.sv
// Frame accumulator around a single 16-bit ripple-carry adder: sums a valid/ready operand stream
// per in_last-delimited frame and presents the sum with sticky carry/overflow flags downstream.
module adder16_accum_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [15:0]      r_acc;
  logic             r_carry_s;
  logic             r_ovf_s;
  logic [CNT_W-1:0] r_count;

  logic             r_out_valid;
  logic [15:0]      r_out_sum;
  logic             r_out_carry;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_out_count;

  logic [1:0]       w_state_nxt;
  logic [15:0]      w_x;
  logic [15:0]      w_z;
  logic [16:0]      w_c;
  logic             w_add_carry;
  logic             w_add_ovf;
  logic             w_fire;
  logic             w_done;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // The first beat of a frame sees x = 0 so it loads the operand exactly.
  assign w_x = (r_state == StIdle) ? 16'h0000 : r_acc;

  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < 16; i++) begin : g_rca
    assign w_z[i]   = w_x[i] ^ in_data[i] ^ w_c[i];
    assign w_c[i+1] = (w_x[i] & in_data[i]) | (w_c[i] & (w_x[i] ^ in_data[i]));
  end

  assign w_add_carry = w_c[16];
  assign w_add_ovf   = w_c[16] ^ w_c[15];

  assign in_ready = (r_state != StHold);
  assign w_fire   = in_valid & in_ready;
  assign w_done   = r_out_valid & out_ready;

  assign w_carry_nxt = r_carry_s | w_add_carry;
  assign w_ovf_nxt   = r_ovf_s | w_add_ovf;
  assign w_count_nxt = (r_count == CntMax) ? CntMax : r_count + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StAccum: begin
        if (w_fire) w_state_nxt = in_last ? StHold : StAccum;
      end
      StHold: begin
        if (w_done) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_carry_s   <= 1'b0;
      r_ovf_s     <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_carry <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_acc     <= w_z;
        r_carry_s <= w_carry_nxt;
        r_ovf_s   <= w_ovf_nxt;
        r_count   <= w_count_nxt;
        if (in_last) begin
          r_out_valid <= 1'b1;
          r_out_sum   <= w_z;
          r_out_carry <= w_carry_nxt;
          r_out_ovf   <= w_ovf_nxt;
          r_out_count <= w_count_nxt;
        end
      end else if (w_done) begin
        // Result consumed: clear the frame state; the presented fields keep their last values.
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_carry_s   <= 1'b0;
        r_ovf_s     <= 1'b0;
        r_count     <= '0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_carry    = r_out_carry;
  assign out_overflow = r_out_ovf;
  assign out_count    = r_out_count;
  assign out_sign     = r_out_sum[15];
  assign out_zero     = (r_out_sum == 16'h0000);
  assign out_parity   = ~(^r_out_sum);

endmodule
